// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the round-robin Wishbone crossbar.
package wb_xbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int MAX_M     = 8;
  localparam int MAX_S     = 16;
  localparam int MAX_MIDX_W = 3;
  localparam int MAX_SIDX_W = 4;
  localparam int BUS_DW    = 32;
  localparam int SELB      = BUS_DW / 8;

  // Width needed to index v items; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module wb_rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         en_i,
  output logic [W-1:0] gnt_o,
  output logic         vld_o
);

  // Scan from the pointer so the most recently served master has lowest priority.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (int'(ptr_i) + i) % N;
      if (en_i && !vld_o && req_i[j]) begin
        gnt_o = W'(j);
        vld_o = 1'b1;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/wb_xbar_rr.sv
// Shared-bus Wishbone interconnect: round-robin master grant held for a whole
// cyc burst, top-address slave decode, and a per-access timeout watchdog.
module wb_xbar_rr
  import wb_xbar_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_M*DW-1:0]    m_data_i,
  output logic [NUM_M*DW-1:0]    m_data_o,
  input  logic [NUM_M*AW-1:0]    m_addr_i,
  input  logic [NUM_M*DW/8-1:0]  m_sel_i,
  input  logic [NUM_M-1:0]       m_we_i,
  input  logic [NUM_M-1:0]       m_cyc_i,
  input  logic [NUM_M-1:0]       m_stb_i,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic [NUM_M-1:0]       m_err_o,
  output logic [NUM_M-1:0]       m_rty_o,
  input  logic [NUM_S*DW-1:0]    s_data_i,
  output logic [NUM_S*DW-1:0]    s_data_o,
  output logic [NUM_S*AW-1:0]    s_addr_o,
  output logic [NUM_S*DW/8-1:0]  s_sel_o,
  output logic [NUM_S-1:0]       s_we_o,
  output logic [NUM_S-1:0]       s_cyc_o,
  output logic [NUM_S-1:0]       s_stb_o,
  input  logic [NUM_S-1:0]       s_ack_i,
  input  logic [NUM_S-1:0]       s_err_i,
  input  logic [NUM_S-1:0]       s_rty_i
);

  localparam int MW = clog2(NUM_M);
  localparam int CW = clog2(TIMEOUT);
  localparam int SB = DW / 8;

  state_e         state_q, state_d;
  logic [MW-1:0]  owner_q, owner_d;
  logic [MW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [MW-1:0]  gnt_s;
  logic           gnt_vld_s;
  logic           busy_s;
  logic           own_cyc_s, own_stb_s, own_we_s;
  logic [AW-1:0]  own_addr_s;
  logic [DW-1:0]  own_data_s;
  logic [SB-1:0]  own_sel_s;
  logic [SEL_W-1:0] idx_s;
  logic           mapped_s;
  logic           sl_ack_s, sl_err_s, sl_rty_s;
  logic [DW-1:0]  sl_data_s;
  logic           unm_err_s, resp_s, to_s;

  wb_rr_arbiter #(.N(NUM_M), .W(MW)) u_arb (
    .req_i (m_cyc_i),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt_s),
    .vld_o (gnt_vld_s)
  );

  // State, owner, pointer and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant on an IDLE cycle; a release hands priority to the next master up.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld_s) begin
          owner_d = gnt_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!own_cyc_s) begin
          state_d = IDLE;
          ptr_d   = (owner_q == MW'(NUM_M - 1)) ? '0 : owner_q + MW'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner select, slave decode and response return; everything gated by BUSY.
  always_comb begin
    busy_s     = (state_q == BUSY);
    own_cyc_s  = 1'b0;
    own_stb_s  = 1'b0;
    own_we_s   = 1'b0;
    own_addr_s = '0;
    own_data_s = '0;
    own_sel_s  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      logic hit;
      hit = (owner_q == MW'(k));
      own_cyc_s  = own_cyc_s | (hit & m_cyc_i[k]);
      own_stb_s  = own_stb_s | (hit & m_stb_i[k]);
      own_we_s   = own_we_s  | (hit & m_we_i[k]);
      own_addr_s = own_addr_s | ({AW{hit}} & m_addr_i[k*AW +: AW]);
      own_data_s = own_data_s | ({DW{hit}} & m_data_i[k*DW +: DW]);
      own_sel_s  = own_sel_s  | ({SB{hit}} & m_sel_i[k*SB +: SB]);
    end
    idx_s    = own_addr_s[AW-1 -: SEL_W];
    mapped_s = (int'(idx_s) < NUM_S);

    sl_ack_s  = 1'b0;
    sl_err_s  = 1'b0;
    sl_rty_s  = 1'b0;
    sl_data_s = '0;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    s_we_o    = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    for (int s = 0; s < NUM_S; s++) begin
      logic hit;
      hit = busy_s & mapped_s & (idx_s == SEL_W'(s));
      s_cyc_o[s] = hit & own_cyc_s;
      s_stb_o[s] = hit & own_stb_s;
      s_we_o[s]  = hit & own_we_s;
      s_addr_o[s*AW +: AW] = {AW{hit}} & own_addr_s;
      s_data_o[s*DW +: DW] = {DW{hit}} & own_data_s;
      s_sel_o[s*SB +: SB]  = {SB{hit}} & own_sel_s;
      sl_ack_s  = sl_ack_s | (hit & s_ack_i[s]);
      sl_err_s  = sl_err_s | (hit & s_err_i[s]);
      sl_rty_s  = sl_rty_s | (hit & s_rty_i[s]);
      sl_data_s = sl_data_s | ({DW{hit}} & s_data_i[s*DW +: DW]);
    end

    unm_err_s = busy_s & ~mapped_s & own_stb_s;
    resp_s    = sl_ack_s | sl_err_s | sl_rty_s | unm_err_s;
    to_s      = busy_s & own_stb_s & ~resp_s & (cnt_q == CW'(TIMEOUT - 1));

    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    m_data_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      logic hit;
      hit = busy_s & (owner_q == MW'(k));
      m_ack_o[k] = hit & sl_ack_s;
      m_err_o[k] = hit & (sl_err_s | unm_err_s | to_s);
      m_rty_o[k] = hit & sl_rty_s;
      m_data_o[k*DW +: DW] = {DW{hit}} & sl_data_s;
    end
  end

  // Watchdog counts silent strobe cycles and wraps when it forces an err.
  always_comb begin
    if (busy_s && own_cyc_s && own_stb_s && !resp_s && (cnt_q != CW'(TIMEOUT - 1))) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed plus randomized bench for wb_xbar_rr against a behavioural model.
module tb_wb_xbar_rr;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam int SB = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [NM*DW-1:0] m_data_i, m_data_o;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*SB-1:0] m_sel_i;
  logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i, m_ack_o, m_err_o, m_rty_o;
  logic [NS*DW-1:0] s_data_i, s_data_o;
  logic [NS*AW-1:0] s_addr_o;
  logic [NS*SB-1:0] s_sel_o;
  logic [NS-1:0]    s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;

  always #5 clk = ~clk;

  wb_xbar_rr #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_data_i(m_data_i), .m_data_o(m_data_o), .m_addr_i(m_addr_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_data_i(s_data_i), .s_data_o(s_data_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the bus, who is next in line, silent strobe run length.
  bit md_busy;
  int md_owner, md_next, md_silent_run;
  bit e_silent;
  logic [NM*DW-1:0] e_m_data;
  logic [NM-1:0]    e_m_ack, e_m_err, e_m_rty;
  logic [NS*DW-1:0] e_s_data;
  logic [NS*AW-1:0] e_s_addr;
  logic [NS*SB-1:0] e_s_sel;
  logic [NS-1:0]    e_s_we, e_s_cyc, e_s_stb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_busy = 1'b0; md_owner = 0; md_next = 0; md_silent_run = 0;
  endtask

  task automatic predict();
    int o, idx;
    logic [AW-1:0] a;
    logic stb, resp;
    e_m_data = '0; e_m_ack = '0; e_m_err = '0; e_m_rty = '0;
    e_s_data = '0; e_s_addr = '0; e_s_sel = '0; e_s_we = '0; e_s_cyc = '0; e_s_stb = '0;
    e_silent = 1'b0;
    if (md_busy) begin
      o = md_owner;
      a = m_addr_i[o*AW +: AW];
      idx = int'(a[AW-1 -: SW]);
      stb = m_stb_i[o];
      if (idx < NS) begin
        e_s_cyc[idx] = m_cyc_i[o];
        e_s_stb[idx] = stb;
        e_s_we[idx]  = m_we_i[o];
        e_s_addr[idx*AW +: AW] = a;
        e_s_data[idx*DW +: DW] = m_data_i[o*DW +: DW];
        e_s_sel[idx*SB +: SB]  = m_sel_i[o*SB +: SB];
        e_m_ack[o] = s_ack_i[idx];
        e_m_err[o] = s_err_i[idx];
        e_m_rty[o] = s_rty_i[idx];
        e_m_data[o*DW +: DW] = s_data_i[idx*DW +: DW];
        resp = s_ack_i[idx] | s_err_i[idx] | s_rty_i[idx];
      end else begin
        e_m_err[o] = stb;
        resp = stb;
      end
      e_silent = stb && !resp;
      if (e_silent && (md_silent_run + 1 == TO)) e_m_err[o] = 1'b1;
    end
  endtask

  task automatic compare_all();
    predict();
    chk("m_data", m_data_o, e_m_data);
    chk("m_ack", m_ack_o, e_m_ack);
    chk("m_err", m_err_o, e_m_err);
    chk("m_rty", m_rty_o, e_m_rty);
    chk("s_cyc", s_cyc_o, e_s_cyc);
    chk("s_stb", s_stb_o, e_s_stb);
    chk("s_we", s_we_o, e_s_we);
    chk("s_addr", s_addr_o, e_s_addr);
    chk("s_data", s_data_o, e_s_data);
    chk("s_sel", s_sel_o, e_s_sel);
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int best, bestd, d;
    if (rst) begin
      model_reset();
    end else if (!md_busy) begin
      best = -1; bestd = NM;
      for (int m = 0; m < NM; m++) begin
        d = (m - md_next + NM) % NM;
        if (m_cyc_i[m] && d < bestd) begin best = m; bestd = d; end
      end
      if (best >= 0) begin md_busy = 1'b1; md_owner = best; end
      md_silent_run = 0;
    end else begin
      if (e_silent) md_silent_run = (md_silent_run + 1 == TO) ? 0 : md_silent_run + 1;
      else md_silent_run = 0;
      if (!m_cyc_i[md_owner]) begin
        md_busy = 1'b0; md_next = (md_owner + 1) % NM; md_silent_run = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input logic [31:0] addr,
                       input bit we, input logic [31:0] data);
    m_cyc_i[k] = cyc; m_stb_i[k] = stb; m_we_i[k] = we;
    m_addr_i[k*AW +: AW] = addr; m_data_i[k*DW +: DW] = data; m_sel_i[k*SB +: SB] = 4'hF;
  endtask

  task automatic async_rst();
    rst = 1'b1;
    model_reset();
  endtask

  int order [3];
  int exp_order [3];
  int first_err, err_cnt, w;

  initial begin
    rst = 1'b1; model_reset();
    m_data_i = '0; m_addr_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_data_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single master read from slave 1, ack on the second strobe cycle.
    set_m(0, 1'b1, 1'b1, 32'h1000_0004, 1'b0, 32'h0);
    tick();
    chk("single_stb", s_stb_o, 4'b0010);
    tick();
    s_ack_i[1] = 1'b1; s_data_i[1*DW +: DW] = 32'hDEAD_BEEF;
    #1;
    chk("single_data", m_data_o, 64'h0000_0000_DEAD_BEEF);
    chk("single_ack", m_ack_o, 2'b01);
    tick();
    set_m(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0); s_ack_i = '0; s_data_i = '0;
    tick(); tick();

    // Simultaneous requests: m0 first, one idle cycle, then m1, then back to m0.
    async_rst(); tick(); rst = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h2000_0000, 1'b0, 32'h0);
    tick();
    chk("arb_first_m0", s_cyc_o, 4'b0001);
    tick();
    m_cyc_i[0] = 1'b0;
    tick();
    chk("arb_idle_gap", s_cyc_o, 4'b0000);
    tick();
    chk("arb_then_m1", s_cyc_o, 4'b0100);
    m_cyc_i[0] = 1'b1; m_cyc_i[1] = 1'b0;
    tick();
    chk("arb_release_first", s_cyc_o, 4'b0000);
    tick();
    chk("arb_back_m0", s_cyc_o, 4'b0001);
    m_cyc_i = '0;
    tick(); tick();

    // Three contending bursts after reset.
    async_rst(); tick(); rst = 1'b0;
    m_cyc_i = 2'b11;
    for (int b = 0; b < 3; b++) begin
      w = 0;
      while (s_cyc_o == 4'b0000 && w < 6) begin tick(); w++; end
      order[b] = (s_cyc_o == 4'b0001) ? 0 : (s_cyc_o == 4'b0100) ? 1 : -1;
      chk($sformatf("burst_order_%0d", b), order[b], exp_order[b]);
      tick();
      if (order[b] >= 0) m_cyc_i[order[b]] = 1'b0;
      tick();
      m_cyc_i = 2'b11;
    end
    m_cyc_i = '0;
    tick(); tick(); tick();

    // Unmapped write gets an immediate err and drives no slave.
    set_m(1, 1'b1, 1'b1, 32'hF000_0000, 1'b1, 32'h1234_5678);
    tick();
    while (s_cyc_o == 4'b0000 && m_err_o == 2'b00 && w < 12) begin tick(); w++; end
    chk("unmapped_err", m_err_o, 2'b10);
    chk("unmapped_no_cyc", s_cyc_o, 4'b0000);
    tick();
    set_m(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();

    // Silent slave: forced err on the 16th and 32nd strobe cycles.
    async_rst(); tick(); rst = 1'b0;
    set_m(0, 1'b1, 1'b1, 32'h3000_0000, 1'b0, 32'h0);
    tick();
    first_err = 0; err_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (m_err_o[0]) begin
        err_cnt++;
        if (first_err == 0) first_err = k;
      end
      tick();
    end
    chk("timeout_first", first_err, 16);
    chk("timeout_count", err_cnt, 2);
    set_m(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();

    // Asynchronous reset mid-burst drops strobes and responses at once.
    set_m(0, 1'b1, 1'b1, 32'h2000_0000, 1'b1, 32'hA5A5_A5A5);
    tick(); tick();
    chk("rst_pre_stb", s_stb_o, 4'b0100);
    s_ack_i[2] = 1'b1;
    #1;
    chk("rst_pre_ack", m_ack_o, 2'b01);
    async_rst();
    #1;
    chk("rst_stb_drop", s_stb_o, 4'b0000);
    chk("rst_cyc_drop", s_cyc_o, 4'b0000);
    chk("rst_ack_drop", m_ack_o, 2'b00);
    s_ack_i = '0;
    set_m(1, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_first_m0", s_cyc_o, 4'b0100);
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < NM; k++) begin
        if (m_cyc_i[k]) m_cyc_i[k] = ($urandom_range(0, 5) != 0);
        else m_cyc_i[k] = ($urandom_range(0, 2) == 0);
        m_stb_i[k] = m_cyc_i[k] & ($urandom_range(0, 3) != 0);
        m_we_i[k] = 1'($urandom_range(0, 1));
        m_addr_i[k*AW +: AW] = {4'($urandom_range(0, 5)), 28'($urandom)};
        m_data_i[k*DW +: DW] = $urandom;
        m_sel_i[k*SB +: SB] = 4'($urandom);
      end
      for (int s = 0; s < NS; s++) begin
        int r;
        r = $urandom_range(0, 11);
        s_ack_i[s] = (r < 3);
        s_err_i[s] = (r == 3);
        s_rty_i[s] = (r == 4);
        s_data_i[s*DW +: DW] = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
